// File: rtl/cnn_frame_streamer.sv
// Frame buffer + raster streamer feeding the CNN pixel interface, then waits for its class.
// Optional WAIT_RES watchdog enabled by defining STREAMER_TIMEOUT_EN.
module cnn_frame_streamer #(
    parameter int WIDTH          = 28,
    parameter int HEIGHT         = 28,
    parameter int DATA_BITS      = 32,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_en,
    input  logic [ADDR_W-1:0]    load_addr,
    input  logic [DATA_BITS-1:0] load_data,
    input  logic                 start,
    output logic                 busy,
    output logic [DATA_BITS-1:0] pix_data,
    output logic                 pix_val,
    input  logic                 cnn_val,
    input  logic [3:0]           cnn_decision,
    output logic [3:0]           result,
    output logic                 done,
    output logic                 timeout
);
    localparam int N = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    cnt;
    logic [DATA_BITS-1:0] mem [0:N-1];
    logic                 wr_ok;
    logic                 res_take;
    logic                 res_to;
    logic                 wd_expire;

    // Host writes are blocked only while the frame is being read out.
    assign wr_ok = load_en && (state != STREAM) && ({1'b0, load_addr} < N_EXT);
    assign busy  = (state != IDLE);

    always_ff @(posedge clk) begin
        if (wr_ok) mem[load_addr] <= load_data;
    end

`ifdef STREAMER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [WD_W-1:0] wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   wd <= '0;
        else if (state == WAIT_RES) wd <= wd + 1'b1;
        else                       wd <= '0;
    end

    // wd is 0 on the first WAIT_RES cycle, so expiry lands TIMEOUT_CYCLES after entry.
    assign wd_expire = (state == WAIT_RES) && (wd == WD_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wd_expire = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        res_take  = 1'b0;
        res_to    = 1'b0;
        case (state)
            IDLE:     if (start) state_nxt = STREAM;
            STREAM:   if (cnt == LAST_IDX) state_nxt = WAIT_RES;
            WAIT_RES: begin
                if (cnn_val) begin
                    res_take  = 1'b1;
                    state_nxt = IDLE;
                end else if (wd_expire) begin
                    res_to    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            pix_val  <= 1'b0;
            pix_data <= '0;
            result   <= 4'h0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == STREAM) cnt <= (cnt == LAST_IDX) ? '0 : cnt + 1'b1;
            else                 cnt <= '0;
            // pix_val is delayed one cycle to line up with the synchronous RAM read.
            pix_val <= (state == STREAM);
            if (state == STREAM) pix_data <= mem[cnt];
            done    <= res_take | res_to;
            timeout <= res_to;
            if (res_take)    result <= cnn_decision;
            else if (res_to) result <= 4'hF;
        end
    end
endmodule

// File: tb/tb_cnn_frame_streamer.sv
// Bench for cnn_frame_streamer: cycle-indexed frame model plus directed scenarios.
module tb_cnn_frame_streamer;
    localparam int W = 28, H = 28, DB = 32, AW = 10, TO = 16, N = W * H;

    logic          clk = 1'b0, rst = 1'b1;
    logic          load_en = 1'b0, start = 1'b0, cnn_val = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DB-1:0] load_data = '0;
    logic [3:0]    cnn_decision = 4'h0;
    logic          busy, pix_val, done, timeout;
    logic [DB-1:0] pix_data;
    logic [3:0]    result;

    cnn_frame_streamer #(.WIDTH(W), .HEIGHT(H), .DATA_BITS(DB), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .busy(busy), .pix_data(pix_data), .pix_val(pix_val), .cnn_val(cnn_val),
        .cnn_decision(cnn_decision), .result(result), .done(done), .timeout(timeout));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: a frame started at cycle t0 shows pixel k at cycle t0+2+k, and the result
    // window opens at t0+N+1; the class (or timeout) appears the cycle after it is taken.
    logic [DB-1:0] ref_buf [N];
    bit            m_active = 1'b0, m_done = 1'b0, m_to = 1'b0;
    int            m_t0 = 0;
    logic [3:0]    m_result = 4'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0; m_done = 1'b0; m_to = 1'b0; m_result = 4'h0;
        end else begin
            m_done = 1'b0; m_to = 1'b0;
            if (!m_active) begin
                if (load_en && int'(load_addr) < N) ref_buf[load_addr] = load_data;
                if (start) begin m_active = 1'b1; m_t0 = cyc; end
            end else if (cyc >= m_t0 + N + 1) begin
                if (load_en && int'(load_addr) < N) ref_buf[load_addr] = load_data;
                if (cnn_val) begin
                    m_result = cnn_decision; m_done = 1'b1; m_active = 1'b0;
                end
`ifdef STREAMER_TIMEOUT_EN
                else if (cyc - (m_t0 + N + 1) == TO - 1) begin
                    m_result = 4'hF; m_done = 1'b1; m_to = 1'b1; m_active = 1'b0;
                end
`endif
            end
        end
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            bit ev;
            ev = m_active && (cyc >= m_t0 + 2) && (cyc <= m_t0 + N + 1);
            chk("busy", busy, m_active);
            chk("pix_val", pix_val, ev);
            if (ev) chk("pix_data", pix_data, ref_buf[cyc - m_t0 - 2]);
            chk("done", done, m_done);
            chk("timeout", timeout, m_to);
            chk("result", result, m_result);
        end
    end

    // Observation log for the hand-computed checks.
    logic [DB-1:0] cap [N];
    int cap_cnt = 0, cap_first = 0, done_cnt = 0, done_cyc = 0, to_cnt = 0;
    always @(negedge clk) begin
        if (pix_val) begin
            if (cap_cnt == 0) cap_first = cyc;
            if (cap_cnt < N) cap[cap_cnt] = pix_data;
            cap_cnt++;
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        if (timeout) to_cnt++;
    end

    task automatic step; @(posedge clk); #2; endtask
    task automatic clr_mon; cap_cnt = 0; done_cnt = 0; to_cnt = 0; endtask
    task automatic wait_until(input int target); while (cyc < target) step(); endtask

    task automatic kick(output int t);
        start = 1'b1; t = cyc; step(); start = 1'b0;
    endtask

    task automatic answer(input logic [3:0] d);
        cnn_val = 1'b1; cnn_decision = d; step(); cnn_val = 1'b0; step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        repeat (3) step();
        chk("rst_busy", busy, 1'b0);   chk("rst_pix_val", pix_val, 1'b0);
        chk("rst_pix_data", pix_data, 32'h0); chk("rst_result", result, 4'h0);
        chk("rst_done", done, 1'b0);   chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0; step();

        // 1 + 6: full ramp frame, stale cnn_val during STREAM
        for (int i = 0; i < N; i++) begin
            load_en = 1'b1; load_addr = AW'(i); load_data = DB'(i); step();
        end
        load_en = 1'b0; step();
        clr_mon();
        kick(t);
        wait_until(t + 100);
        cnn_val = 1'b1; cnn_decision = 4'd4;
        wait_until(t + 110);
        cnn_val = 1'b0;
        wait_until(t + N + 40);
        chk("t1_count", cap_cnt, N);        chk("t1_first", cap_first, t + 2);
        chk("t1_pix0", cap[0], 32'd0);      chk("t1_pix5", cap[5], 32'd5);
        chk("t1_pixlast", cap[N-1], 32'd783);
        chk("t6_no_done", done_cnt, 0);     chk("t6_result", result, 4'h0);
        chk("t1_busy_wait", busy, 1'b1);

        // 2: class returned, start in the same cycle ignored
        start = 1'b1; cnn_val = 1'b1; cnn_decision = 4'd7; step();
        start = 1'b0; cnn_val = 1'b0;
        chk("t2_result", result, 4'd7); chk("t2_done", done, 1'b1); chk("t2_busy", busy, 1'b0);
        step();
        chk("t2_done_pulse", done, 1'b0); chk("t2_start_ignored", busy, 1'b0);

        // 3: writes/starts during STREAM ignored; write in WAIT_RES accepted
        clr_mon();
        kick(t);
        wait_until(t + 50);
        load_en = 1'b1; load_addr = AW'(5); load_data = 32'hDEAD; step(); load_en = 1'b0;
        wait_until(t + 60);
        start = 1'b1; step(); start = 1'b0;
        wait_until(t + N + 5);
        load_en = 1'b1; load_addr = AW'(10); load_data = 32'h1234; step(); load_en = 1'b0;
        chk("t3_pix5", cap[5], 32'd5); chk("t3_count", cap_cnt, N);
        answer(4'd3);
        load_en = 1'b1; load_addr = AW'(800); load_data = 32'hBEEF; step(); load_en = 1'b0;
        step();

        // 4: reset mid-frame, then replay
        clr_mon();
        kick(t);
        for (int k = 0; k < 1000 && cap_cnt < 300; k++) step();
        chk("t4_reached300", cap_cnt, 300);
        rst = 1'b1; #1;
        chk("t4_pix_val", pix_val, 1'b0); chk("t4_busy", busy, 1'b0);
        chk("t4_done", done, 1'b0);       chk("t4_result", result, 4'h0);
        step(); step(); rst = 1'b0; step();
        clr_mon();
        kick(t);
        wait_until(t + N + 5);
        chk("t4_pix0", cap[0], 32'd0); chk("t4_pix5", cap[5], 32'd5);
        chk("t4_pix10", cap[10], 32'h1234); chk("t4_count", cap_cnt, N);

`ifdef STREAMER_TIMEOUT_EN
        // 5a: watchdog expiry 16 cycles after WAIT_RES entry
        clr_mon();
        wait_until(t + N + 40);
        chk("t5_done_cyc", done_cyc, t + N + 1 + TO);
        chk("t5_result", result, 4'hF); chk("t5_to_cnt", to_cnt, 1);
        // 5b: cnn_val on the expiry cycle wins
        clr_mon();
        kick(t);
        wait_until(t + N + 1 + TO - 1);
        answer(4'd9);
        step();
        chk("t5b_result", result, 4'd9); chk("t5b_to_cnt", to_cnt, 0);
        chk("t5b_done_cyc", done_cyc, t + N + 1 + TO);
`else
        wait_until(t + N + 60);
        chk("t5_still_waiting", busy, 1'b1); chk("t5_no_timeout", to_cnt, 0);
        answer(4'd2);
        chk("t5_result", result, 4'd2);
`endif
        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
